dmem_scheduler: RTL and testbench
=================================

# dmem_scheduler

Shared data-memory scheduler and run controller for the multi-core matrix-multiplication array. It starts all cores together and round-robin arbitrates their requests onto one single-port data memory. Losing requesters are held through each core's `status` input, and `end_process` flags are collected into a global `done`. It sits between the core instances (`core_0` … `core_N-1`) and the data memory.

## Interface
Parameters:
- `NUM_CORES`, 4: number of cores sharing the memory (2–8).
- `ADDR_W`, 8: data-memory address width.
- `DATA_W`, 16: data-memory word width.

Ports:
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level; launch a run when sampled high in IDLE.
- `core_req`  in  NUM_CORES  per-core memory-access request, held until granted.
- `core_we`  in  NUM_CORES  per-core write enable (meaningful with `core_req`).
- `core_addr`  in  NUM_CORES*ADDR_W  per-core address; core i at bits [i*ADDR_W +: ADDR_W].
- `core_din`  in  NUM_CORES*DATA_W  per-core write data; same packing.
- `core_end`  in  NUM_CORES  per-core `end_process`.
- `core_status`  out  2*NUM_CORES  per-core status; core i at bits [2i+1:2i].
- `core_dout`  out  DATA_W  read data broadcast to all cores; equals `mem_dout`.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_din`  out  DATA_W  memory write data.
- `mem_dout`  in  DATA_W  memory read data; synchronous RAM, valid one cycle after address.
- `done`  out  1  one-cycle pulse at run completion.
- `run_cycles`  out  16  cycles spent in RUN for the last/current run; saturates at 16'hFFFF.

## Operation
- Status codes: 2'b00 IDLE (core held), 2'b01 RUN, 2'b10 STALL (freeze this cycle), 2'b11 FINISH.
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN when `start`=1.
  - RUN → DONE when every `end_seen` bit is 1, including `core_end` bits arriving this cycle.
  - DONE → IDLE unconditionally after 1 cycle.
- `end_seen[i]` is set when `core_end[i]`=1 in RUN. It is sticky and cleared on entry to RUN and on `reset`.
- Arbitration is combinational in RUN only.
  - Eligible requesters: `core_req[i] & ~end_seen[i]`.
  - The winner is the first eligible index searching upward from `last_grant+1`, wrapping modulo NUM_CORES.
  - `last_grant` updates to the winner on each grant and is not updated when nothing is granted.
- Memory drive:
  - With a winner g: `mem_addr`=`core_addr[g]`, `mem_din`=`core_din[g]`, `mem_we`=`core_we[g]`.
  - With no winner, or outside RUN: all three are 0.
- `core_status[i]` by state:
  - IDLE: 00.
  - DONE: 11.
  - RUN:
    - 11 if `end_seen[i]`.
    - Else 10 if eligible and not the winner.
    - Else 01.
- `run_cycles` clears on IDLE→RUN and increments every cycle in RUN, saturating. It holds in DONE and IDLE.
- `done`=1 only in DONE.

## Timing
- Reset values:
  - FSM state is IDLE.
  - `last_grant` is NUM_CORES-1, so core 0 wins first.
  - `end_seen`=0, `run_cycles`=0, `done`=0, all `core_status`=00.
  - `mem_we`=0, `mem_addr`=0, `mem_din`=0.
- `reset` mid-run is immediate at the next edge: state IDLE, all registers as above, and no further write is issued after that edge.
- Grant and status are same-cycle combinational from `core_req`.
- A stalled core keeps its request asserted and is re-arbitrated next cycle.
- Writes commit at the grant edge.
- Read data appears on `core_dout` the cycle after grant. Only the core granted in the previous cycle samples it.
- Fairness: with all NUM_CORES cores requesting continuously, each is granted exactly once per NUM_CORES cycles.
- `start` held high through DONE re-launches a run on the cycle after IDLE is re-entered.

## Test plan
- Reset, then `start`=1 for 1 cycle.
  - All status goes 00→01.
  - `run_cycles` counts 1, 2, 3…
- NUM_CORES=4, all `core_req`=1 continuously.
  - Grants go 0, 1, 2, 3, 0…
  - Each non-winner shows 10.
  - `mem_addr` tracks the winner's address.
- Core 2 writes 16'h1234 to address 8'h10; next cycle core 2 reads 8'h10.
  - `mem_we`=1 on the first cycle.
  - `core_dout`=16'h1234 on the cycle after the read grant.
- Core 1 asserts `core_end` while requesting.
  - Status 11 from the next cycle.
  - Its `core_req` is ignored thereafter.
  - Remaining cores rotate 0, 2, 3.
- All cores end.
  - One DONE cycle with `done`=1 and all status 11.
  - Then IDLE, with all 00 and `run_cycles` frozen.
- `reset` asserted mid-run while core 0 is granted a write.
  - No write after the reset edge.
  - All outputs at reset values.
  - The next run grants core 0 first.

Source files
------------

// File: rtl/dmem_scheduler.sv
// dmem_scheduler: launches all matrix cores together, round-robin arbitrates their
// requests onto one single-port data memory and collects end_process into done.
module dmem_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_din,
    input  logic [NUM_CORES-1:0]        core_end,
    output logic [2*NUM_CORES-1:0]      core_status,
    output logic [DATA_W-1:0]           core_dout,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_din,
    input  logic [DATA_W-1:0]           mem_dout,
    output logic                        done,
    output logic [15:0]                 run_cycles
);

    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_STALL  = 2'b10;
    localparam logic [1:0] ST_FINISH = 2'b11;

    state_t               state;
    state_t               state_next;
    logic [GW-1:0]        last_grant;
    logic [GW-1:0]        grant_idx;
    logic                 grant_valid;
    logic [NUM_CORES-1:0] end_seen;
    logic [NUM_CORES-1:0] eligible;

    assign eligible  = core_req & ~end_seen;
    assign core_dout = mem_dout;
    assign done      = (state == S_DONE);

    // Completion counts end_process pulses arriving this cycle, not only the sticky ones.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (&(end_seen | core_end)) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= GW'(NUM_CORES - 1);
            end_seen   <= '0;
            run_cycles <= '0;
        end else begin
            state <= state_next;
            if (grant_valid) last_grant <= grant_idx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        end_seen   <= '0;
                        run_cycles <= '0;
                    end
                end
                S_RUN: begin
                    end_seen <= end_seen | core_end;
                    if (run_cycles != 16'hFFFF) run_cycles <= run_cycles + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Search upward from the core after the last winner, wrapping modulo NUM_CORES.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (state == S_RUN) begin
            for (int k = 1; k <= NUM_CORES; k++) begin
                idx = (int'(last_grant) + k) % NUM_CORES;
                if (!grant_valid && eligible[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = GW'(idx);
                end
            end
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant_valid && grant_idx == GW'(i)) begin
                mem_we   = core_we[i];
                mem_addr = core_addr[i*ADDR_W +: ADDR_W];
                mem_din  = core_din[i*DATA_W +: DATA_W];
            end
        end
    end

    // Losing eligible requesters are frozen with STALL and retried next cycle.
    always_comb begin
        core_status = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            case (state)
                S_RUN: begin
                    if (end_seen[i])
                        core_status[2*i +: 2] = ST_FINISH;
                    else if (eligible[i] && !(grant_valid && grant_idx == GW'(i)))
                        core_status[2*i +: 2] = ST_STALL;
                    else
                        core_status[2*i +: 2] = ST_RUN;
                end
                S_DONE:  core_status[2*i +: 2] = ST_FINISH;
                default: core_status[2*i +: 2] = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_scheduler.sv
// tb_dmem_scheduler: directed cycle-by-cycle stimulus with a queue of expected
// outputs for dmem_scheduler, backed by a synchronous RAM model.
module tb_dmem_scheduler;

    logic        clock;
    logic        reset;
    logic        start;
    logic [3:0]  core_req;
    logic [3:0]  core_we;
    logic [31:0] core_addr;
    logic [63:0] core_din;
    logic [3:0]  core_end;
    logic [7:0]  core_status;
    logic [15:0] core_dout;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        done;
    logic [15:0] run_cycles;

    logic [15:0] ram [0:255];

    int total;
    int bad;

    typedef struct {
        string       tag;
        logic [7:0]  status;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] din;
        logic        done;
        logic [15:0] rc;
        logic        chk_dout;
        logic [15:0] dout;
    } exp_t;

    exp_t sb[$];

    dmem_scheduler #(.NUM_CORES(4), .ADDR_W(8), .DATA_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_din   (core_din),
        .core_end   (core_end),
        .core_status(core_status),
        .core_dout  (core_dout),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .done       (done),
        .run_cycles (run_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic applyStimulus(input string tag, input logic rst, input logic st,
                                 input logic [3:0] req, input logic [3:0] we, input logic [3:0] en,
                                 input logic [7:0] e_status, input logic e_we, input logic [7:0] e_addr,
                                 input logic [15:0] e_din, input logic e_done, input logic [15:0] e_rc,
                                 input logic e_chk_dout, input logic [15:0] e_dout);
        exp_t e;
        @(negedge clock);
        reset    = rst;
        start    = st;
        core_req = req;
        core_we  = we;
        core_end = en;
        e.tag      = tag;
        e.status   = e_status;
        e.we       = e_we;
        e.addr     = e_addr;
        e.din      = e_din;
        e.done     = e_done;
        e.rc       = e_rc;
        e.chk_dout = e_chk_dout;
        e.dout     = e_dout;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        #1;
        e = sb.pop_front();
        total++;
        assert (core_status === e.status) else begin
            bad++;
            $error("[TB] FAIL %s status: got %h want %h", e.tag, core_status, e.status);
        end
        total++;
        assert (mem_we === e.we) else begin
            bad++;
            $error("[TB] FAIL %s mem_we: got %b want %b", e.tag, mem_we, e.we);
        end
        total++;
        assert (mem_addr === e.addr) else begin
            bad++;
            $error("[TB] FAIL %s mem_addr: got %h want %h", e.tag, mem_addr, e.addr);
        end
        total++;
        assert (mem_din === e.din) else begin
            bad++;
            $error("[TB] FAIL %s mem_din: got %h want %h", e.tag, mem_din, e.din);
        end
        total++;
        assert (done === e.done) else begin
            bad++;
            $error("[TB] FAIL %s done: got %b want %b", e.tag, done, e.done);
        end
        total++;
        assert (run_cycles === e.rc) else begin
            bad++;
            $error("[TB] FAIL %s run_cycles: got %0d want %0d", e.tag, run_cycles, e.rc);
        end
        if (e.chk_dout) begin
            total++;
            assert (core_dout === e.dout) else begin
                bad++;
                $error("[TB] FAIL %s core_dout: got %h want %h", e.tag, core_dout, e.dout);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        start     = 1'b0;
        core_req  = '0;
        core_we   = '0;
        core_end  = '0;
        core_addr = {8'h23, 8'h22, 8'h21, 8'h20};
        core_din  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        $display("[TB] dmem_scheduler directed run");

        // reset and launch
        applyStimulus("reset",   1, 0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 8'h00, 16'h0000, 0, 16'd0, 0, 16'h0); checkOutput();
        applyStimulus("idle",    0, 1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 8'h00, 16'h0000, 0, 16'd0, 0, 16'h0); checkOutput();
        applyStimulus("run0",    0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h55, 0, 8'h00, 16'h0000, 0, 16'd0, 0, 16'h0); checkOutput();
        applyStimulus("run1",    0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h55, 0, 8'h00, 16'h0000, 0, 16'd1, 0, 16'h0); checkOutput();

        // all cores requesting: round robin 0,1,2,3,0
        applyStimulus("rr_g0",   0, 0, 4'b1111, 4'b0000, 4'b0000, 8'hA9, 0, 8'h20, 16'hD000, 0, 16'd2, 0, 16'h0); checkOutput();
        applyStimulus("rr_g1",   0, 0, 4'b1111, 4'b0000, 4'b0000, 8'hA6, 0, 8'h21, 16'hD001, 0, 16'd3, 0, 16'h0); checkOutput();
        applyStimulus("rr_g2",   0, 0, 4'b1111, 4'b0000, 4'b0000, 8'h9A, 0, 8'h22, 16'hD002, 0, 16'd4, 0, 16'h0); checkOutput();
        applyStimulus("rr_g3",   0, 0, 4'b1111, 4'b0000, 4'b0000, 8'h6A, 0, 8'h23, 16'hD003, 0, 16'd5, 0, 16'h0); checkOutput();
        applyStimulus("rr_g0b",  0, 0, 4'b1111, 4'b0000, 4'b0000, 8'hA9, 0, 8'h20, 16'hD000, 0, 16'd6, 0, 16'h0); checkOutput();

        // core 2 write then read back
        core_addr[23:16] = 8'h10;
        core_din[47:32]  = 16'h1234;
        applyStimulus("wr_c2",   0, 0, 4'b0100, 4'b0100, 4'b0000, 8'h55, 1, 8'h10, 16'h1234, 0, 16'd7, 0, 16'h0); checkOutput();
        applyStimulus("rd_c2",   0, 0, 4'b0100, 4'b0000, 4'b0000, 8'h55, 0, 8'h10, 16'h1234, 0, 16'd8, 0, 16'h0); checkOutput();
        applyStimulus("rd_data", 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h55, 0, 8'h00, 16'h0000, 0, 16'd9, 1, 16'h1234); checkOutput();
        core_addr[23:16] = 8'h22;
        core_din[47:32]  = 16'hD002;

        // core 1 finishes while requesting, others rotate 0,2,3
        applyStimulus("end_c1",  0, 0, 4'b1111, 4'b0000, 4'b0010, 8'h6A, 0, 8'h23, 16'hD003, 0, 16'd10, 0, 16'h0); checkOutput();
        applyStimulus("skip_g0", 0, 0, 4'b1111, 4'b0000, 4'b0000, 8'hAD, 0, 8'h20, 16'hD000, 0, 16'd11, 0, 16'h0); checkOutput();
        applyStimulus("skip_g2", 0, 0, 4'b1111, 4'b0000, 4'b0000, 8'h9E, 0, 8'h22, 16'hD002, 0, 16'd12, 0, 16'h0); checkOutput();
        applyStimulus("skip_g3", 0, 0, 4'b1111, 4'b0000, 4'b0000, 8'h6E, 0, 8'h23, 16'hD003, 0, 16'd13, 0, 16'h0); checkOutput();
        applyStimulus("skip_g0b",0, 0, 4'b1111, 4'b0000, 4'b0000, 8'hAD, 0, 8'h20, 16'hD000, 0, 16'd14, 0, 16'h0); checkOutput();

        // everyone ends: one DONE cycle then IDLE with frozen count
        applyStimulus("end_all", 0, 0, 4'b1111, 4'b0000, 4'b1111, 8'h9E, 0, 8'h22, 16'hD002, 0, 16'd15, 0, 16'h0); checkOutput();
        applyStimulus("done",    0, 0, 4'b1111, 4'b0000, 4'b0000, 8'hFF, 0, 8'h00, 16'h0000, 1, 16'd16, 0, 16'h0); checkOutput();
        applyStimulus("idle_a",  0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 8'h00, 16'h0000, 0, 16'd16, 0, 16'h0); checkOutput();
        applyStimulus("idle_b",  0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 8'h00, 16'h0000, 0, 16'd16, 0, 16'h0); checkOutput();

        // reset lands while core 0 is granted a write
        applyStimulus("launch2", 0, 1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 8'h00, 16'h0000, 0, 16'd16, 0, 16'h0); checkOutput();
        applyStimulus("rst_wr",  1, 0, 4'b0001, 4'b0001, 4'b0000, 8'h55, 1, 8'h20, 16'hD000, 0, 16'd0, 0, 16'h0); checkOutput();
        applyStimulus("post_rst",0, 0, 4'b0001, 4'b0001, 4'b0000, 8'h00, 0, 8'h00, 16'h0000, 0, 16'd0, 0, 16'h0); checkOutput();
        applyStimulus("launch3", 0, 1, 4'b0001, 4'b0000, 4'b0000, 8'h00, 0, 8'h00, 16'h0000, 0, 16'd0, 0, 16'h0); checkOutput();
        applyStimulus("first_g0",0, 0, 4'b1111, 4'b0000, 4'b0000, 8'hA9, 0, 8'h20, 16'hD000, 0, 16'd0, 0, 16'h0); checkOutput();
        applyStimulus("then_g1", 0, 0, 4'b1111, 4'b0000, 4'b0000, 8'hA6, 0, 8'h21, 16'hD001, 0, 16'd1, 0, 16'h0); checkOutput();

        // start held through DONE relaunches right after IDLE
        applyStimulus("end_st",  0, 1, 4'b0000, 4'b0000, 4'b1111, 8'h55, 0, 8'h00, 16'h0000, 0, 16'd2, 0, 16'h0); checkOutput();
        applyStimulus("done_st", 0, 1, 4'b0000, 4'b0000, 4'b0000, 8'hFF, 0, 8'h00, 16'h0000, 1, 16'd3, 0, 16'h0); checkOutput();
        applyStimulus("idle_st", 0, 1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 8'h00, 16'h0000, 0, 16'd3, 0, 16'h0); checkOutput();
        applyStimulus("rerun0",  0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h55, 0, 8'h00, 16'h0000, 0, 16'd0, 0, 16'h0); checkOutput();
        applyStimulus("rerun1",  0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h55, 0, 8'h00, 16'h0000, 0, 16'd1, 0, 16'h0); checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
